// File: rtl/stream_detect_sched.sv
// rtl/stream_detect_sched.sv - shares one serial sequence detector between two byte requesters
// Round-robin at packet granularity, MSB-first serialization, zero flush between packets, per-requester hit counts.
module stream_detect_sched #(
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16,
  parameter int FLUSH_LEN = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_vld,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_last,
  output logic              req0_rdy,
  input  logic              req1_vld,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_last,
  output logic              req1_rdy,
  output logic              det_din,
  output logic              det_vld,
  input  logic              det_result,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  hit_cnt0,
  output logic [CNT_W-1:0]  hit_cnt1,
  output logic              busy,
  output logic              owner
);

  localparam int MAX_LEN = (DATA_W > FLUSH_LEN) ? DATA_W : FLUSH_LEN;
  localparam int BC_W    = $clog2(MAX_LEN + 1);
  localparam logic [BC_W-1:0] DATA_END  = BC_W'(DATA_W - 1);
  localparam logic [BC_W-1:0] FLUSH_END = BC_W'(FLUSH_LEN - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FLUSH} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic              last_flag;
  logic              last_grant;
  logic              cnt_en_d;
  logic              tag_d;
  logic              win1;
  logic              sel;
  logic              take;
  logic [DATA_W-1:0] take_data;
  logic              take_last;

  // rst_n is active-high: rdy is held low while it is asserted
  assign win1      = req1_vld & (~req0_vld | ~last_grant);
  assign req0_rdy  = ~rst_n & (((state == IDLE) & req0_vld & ~win1) | ((state == LOAD) & ~owner));
  assign req1_rdy  = ~rst_n & (((state == IDLE) & win1) | ((state == LOAD) & owner));
  assign sel       = (state == IDLE) ? win1 : owner;
  assign take      = sel ? (req1_vld & req1_rdy) : (req0_vld & req0_rdy);
  assign take_data = sel ? req1_data : req0_data;
  assign take_last = sel ? req1_last : req0_last;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    det_vld   = 1'b0;
    det_din   = 1'b0;
    case (state)
      IDLE:  if (take) state_nxt = SHIFT;
      LOAD:  if (take) state_nxt = SHIFT;
      SHIFT: begin
        det_vld = 1'b1;
        det_din = shreg[DATA_W-1];
        if (bit_cnt == DATA_END) state_nxt = last_flag ? FLUSH : LOAD;
      end
      FLUSH: begin
        det_vld = 1'b1;
        if (bit_cnt == FLUSH_END) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      last_flag  <= 1'b0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt_en_d   <= 1'b0;
      tag_d      <= 1'b0;
    end else begin
      // tag pair lines up with the detector's one-cycle result latency
      cnt_en_d <= (state == SHIFT);
      tag_d    <= owner;
      if (take) begin
        shreg     <= take_data;
        last_flag <= take_last;
        bit_cnt   <= '0;
        if (state == IDLE) begin
          owner      <= win1;
          last_grant <= win1;
        end
      end else if (state == SHIFT) begin
        shreg   <= shreg << 1;
        bit_cnt <= (bit_cnt == DATA_END) ? '0 : bit_cnt + BC_W'(1);
      end else if (state == FLUSH) begin
        bit_cnt <= (bit_cnt == FLUSH_END) ? '0 : bit_cnt + BC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n || cnt_clr)
      hit_cnt0 <= '0;
    else if (det_result && cnt_en_d && !tag_d && !(&hit_cnt0))
      hit_cnt0 <= hit_cnt0 + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst_n || cnt_clr)
      hit_cnt1 <= '0;
    else if (det_result && cnt_en_d && tag_d && !(&hit_cnt1))
      hit_cnt1 <= hit_cnt1 + CNT_W'(1);
  end

endmodule

// File: tb/tb_stream_detect_sched.sv
// tb/tb_stream_detect_sched.sv - scoreboard bench for stream_detect_sched
// Expected serial bits are queued at each handshake; a negedge monitor pops them whenever det_vld is high.
module tb_stream_detect_sched;
  localparam int DATA_W    = 8;
  localparam int CNT_W     = 4;
  localparam int FLUSH_LEN = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req0_vld = 1'b0, req0_last = 1'b0, req0_rdy;
  logic              req1_vld = 1'b0, req1_last = 1'b0, req1_rdy;
  logic [DATA_W-1:0] req0_data = '0, req1_data = '0;
  logic              det_din, det_vld, det_result;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  hit_cnt0, hit_cnt1;
  logic              busy, owner;

  int  checks = 0;
  int  errors = 0;
  bit  exp_q[$];
  bit  mon_en = 1'b0;
  bit  mon_bit;
  bit  hit_all = 1'b0;
  logic det_hit_q = 1'b0;
  logic det_pulse = 1'b0;

  stream_detect_sched #(.DATA_W(DATA_W), .CNT_W(CNT_W), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_vld(req0_vld), .req0_data(req0_data), .req0_last(req0_last), .req0_rdy(req0_rdy),
    .req1_vld(req1_vld), .req1_data(req1_data), .req1_last(req1_last), .req1_rdy(req1_rdy),
    .det_din(det_din), .det_vld(det_vld), .det_result(det_result),
    .cnt_clr(cnt_clr), .hit_cnt0(hit_cnt0), .hit_cnt1(hit_cnt1),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // detector model: registered result, either echoing every valid bit or an explicit pulse
  always @(posedge clk) det_hit_q <= hit_all & det_vld;
  assign det_result = det_hit_q | det_pulse;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && det_vld === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected det_vld", 1, 0);
      else begin
        mon_bit = exp_q.pop_front();
        chk("det_din", det_din, mon_bit);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input int r, input logic [DATA_W-1:0] d, input logic l);
    bit hs = 1'b0;
    bit ok = 1'b0;
    if (r == 0) begin req0_vld = 1'b1; req0_data = d; req0_last = l; end
    else        begin req1_vld = 1'b1; req1_data = d; req1_last = l; end
    #1;
    for (int i = 0; i < 200; i++) begin
      hs = (r == 0) ? req0_rdy : req1_rdy;
      @(posedge clk);
      #1;
      if (hs) begin ok = 1'b1; break; end
    end
    chk("handshake", ok, 1);
    if (r == 0) req0_vld = 1'b0;
    else        req1_vld = 1'b0;
    for (int i = DATA_W - 1; i >= 0; i--) exp_q.push_back(d[i]);
    if (l) for (int i = 0; i < FLUSH_LEN; i++) exp_q.push_back(1'b0);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    chk("idle timeout", ok, 1);
    chk("bits left in queue", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset with both requesters valid
    req0_vld = 1'b1; req0_data = 8'h55;
    req1_vld = 1'b1; req1_data = 8'hAA;
    @(negedge clk);
    chk("rst rdy0", req0_rdy, 0);
    chk("rst rdy1", req1_rdy, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("post-rst rdy0", req0_rdy, 1);
    chk("post-rst rdy1", req1_rdy, 0);
    chk("post-rst owner", owner, 0);
    chk("post-rst busy", busy, 0);
    chk("post-rst det_vld", det_vld, 0);
    chk("post-rst cnt0", hit_cnt0, 0);
    chk("post-rst cnt1", hit_cnt1, 0);
    req0_vld = 1'b0; req1_vld = 1'b0;
    mon_en = 1'b1;

    // single byte, no hit: 1,1,1,0,0,0,0,0 then six flush zeros
    send_byte(0, 8'hE0, 1'b1);
    wait_idle();
    chk("E0 cnt0", hit_cnt0, 0);

    // hit after 6th data bit counts for req1; pulse during flush is ignored
    send_byte(1, 8'hB8, 1'b1);
    cyc(6); det_pulse = 1'b1;
    cyc(1); det_pulse = 1'b0;
    cyc(3); det_pulse = 1'b1;
    cyc(1); det_pulse = 1'b0;
    wait_idle();
    chk("B8 cnt1", hit_cnt1, 1);
    chk("B8 cnt0", hit_cnt0, 0);
    chk("B8 owner", owner, 1);

    // contention: req0 two-byte packet holds the lock while req1 waits
    req1_data = 8'h0F; req1_last = 1'b1; req1_vld = 1'b1;
    send_byte(0, 8'h3C, 1'b0);
    chk("lock owner", owner, 0);
    send_byte(0, 8'hC3, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      chk("locked rdy1", req1_rdy, 0);
    end
    chk("queue after req0 pkt", exp_q.size(), 0);
    chk("grant rdy1", req1_rdy, 1);
    chk("grant rdy0", req0_rdy, 0);
    send_byte(1, 8'h0F, 1'b1);
    chk("grant owner", owner, 1);
    req0_vld = 1'b1; req0_data = 8'h81; req0_last = 1'b1;
    req1_vld = 1'b1; req1_data = 8'h7E; req1_last = 1'b1;
    wait_idle();
    chk("alt rdy0", req0_rdy, 1);
    chk("alt rdy1", req1_rdy, 0);
    req1_vld = 1'b0;
    send_byte(0, 8'h81, 1'b1);
    chk("alt owner", owner, 0);
    wait_idle();

    // saturation: 16 data-bit hits on a 4-bit counter
    hit_all = 1'b1;
    send_byte(0, 8'h12, 1'b0);
    send_byte(0, 8'h34, 1'b1);
    wait_idle();
    hit_all = 1'b0;
    cyc(2);
    chk("sat cnt0", hit_cnt0, 15);
    chk("sat cnt1", hit_cnt1, 1);

    // plain clear, then clear colliding with a hit
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    chk("clr cnt0", hit_cnt0, 0);
    chk("clr cnt1", hit_cnt1, 0);
    hit_all = 1'b1;
    send_byte(0, 8'hF0, 1'b1);
    cyc(4); cnt_clr = 1'b1;
    cyc(1); cnt_clr = 1'b0;
    chk("clr beats hit", hit_cnt0, 0);
    wait_idle();
    hit_all = 1'b0;
    cyc(2);
    chk("post-clr hits", hit_cnt0, 4);

    // reset during the 4th shift cycle: no flush, in-flight result ignored
    send_byte(0, 8'hFF, 1'b1);
    cyc(3); rst_n = 1'b1;
    cyc(1); rst_n = 1'b0;
    exp_q.delete();
    det_pulse = 1'b1;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst det_vld", det_vld, 0);
    chk("midrst cnt0", hit_cnt0, 0);
    chk("midrst owner", owner, 0);
    @(posedge clk); #1;
    det_pulse = 1'b0;
    cyc(10);
    chk("midrst late cnt0", hit_cnt0, 0);
    chk("midrst late cnt1", hit_cnt1, 0);
    chk("midrst queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/stream_detect_sched.md
Name: stream_detect_sched

Overview:
- Shares one serial sequence detector between two byte-wide requesters.
- Arbitrates round-robin at packet granularity. Serializes each accepted byte MSB-first onto the detector's din/din_vld.
- Inserts a zero flush between packets. Counts detector hits per requester.
- Sits between upstream byte sources and the 1-bit detector; the detector's result feeds back into this block.

Parameters:
DATA_W, 8, requester byte width
CNT_W, 16, width of each hit counter
FLUSH_LEN, 6, zero bits shifted between packets to purge detector history

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous, active-high reset
req0_vld  in  1  requester 0 byte valid
req0_data  in  DATA_W  requester 0 byte
req0_last  in  1  requester 0 byte ends packet
req0_rdy  out  1  requester 0 byte accepted when vld&rdy
req1_vld  in  1  requester 1 byte valid
req1_data  in  DATA_W  requester 1 byte
req1_last  in  1  requester 1 byte ends packet
req1_rdy  out  1  requester 1 byte accepted when vld&rdy
det_din  out  1  serial bit to detector
det_vld  out  1  serial bit valid to detector
det_result  in  1  detector match pulse, registered in detector (1-cycle latency after bit)
cnt_clr  in  1  synchronous clear of both hit counters
hit_cnt0  out  CNT_W  saturating hit count, requester 0
hit_cnt1  out  CNT_W  saturating hit count, requester 1
busy  out  1  high in any state except IDLE
owner  out  1  current/last granted requester

Behaviour:
- Reset (rst_n=1 at clk edge) forces:
  - state=IDLE; all rdy=0; det_din=0, det_vld=0.
  - hit_cnt0=hit_cnt1=0; busy=0; owner=0.
  - last_grant=1, so requester 0 wins first.
- Reset mid-operation aborts the packet. No flush is sent. Any in-flight det_result in the cycle after reset is not counted.
- States: IDLE, LOAD, SHIFT, FLUSH.
- IDLE:
  - Winner = requester with vld. If both, winner = the one not equal to last_grant.
  - Only the winner's rdy is high (combinational from vld, state, last_grant). The loser's rdy is low.
  - On handshake: capture data into shift reg, latch last_flag, owner=winner, last_grant=winner, go SHIFT.
- LOAD (packet locked to owner; other requester's rdy=0):
  - owner rdy=1.
  - On handshake: capture data and last_flag, go SHIFT.
  - If owner vld=0: stay in LOAD with det_vld=0. Lock holds until the last byte has been shifted.
- SHIFT:
  - Exactly DATA_W cycles with det_vld=1.
  - det_din=shreg[DATA_W-1], shift left each cycle.
  - After the final bit: go FLUSH if last_flag=1, else LOAD.
  - Both rdy=0 throughout (no back-to-back acceptance; the bubble cycle is intentional).
- FLUSH:
  - FLUSH_LEN cycles, det_vld=1, det_din=0.
  - Then IDLE, where arbitration reopens.
- Attribution:
  - Registered tag pair (cnt_en_d, tag_d) is sampled each cycle.
  - cnt_en_d=1 only for a SHIFT-state data bit; tag_d=owner.
  - On det_result=1 with cnt_en_d=1, increment hit_cnt[tag_d].
  - det_result while cnt_en_d=0 (flush bits, idle) is ignored.
- Counters:
  - Saturate at all-ones with no wrap.
  - cnt_clr has priority over a simultaneous increment; the counter reads 0 the next cycle.
- busy=1 in LOAD/SHIFT/FLUSH.
- A requester changing data while vld=1 and rdy=0 is permitted; only the value at the handshake is used.

Test Plan:
- Reset with both vld=1 → rdy both 0 during reset. First cycle after: req0_rdy=1, req1_rdy=0, owner=0.
- Single byte, no detector hit:
  - Stimulus: req0 sends 8'hE0, last=1; bench detector model never pulses.
  - Required det_din over 8 cycles: 1,1,1,0,0,0,0,0.
  - Then 6 zero bits with det_vld=1, then busy=0. hit_cnt0 stays 0.
- Hit attribution:
  - Stimulus: req1 sends 8'hB8, last=1; bench pulses det_result one cycle after the 6th data bit.
  - Required: hit_cnt1=1, hit_cnt0=0.
  - A det_result pulse injected during FLUSH leaves counts unchanged.
- Contention and packet lock:
  - Stimulus: req0 sends a 2-byte packet (last on byte 2) while req1_vld=1 throughout.
  - Required: req1_rdy=0 until req0 flush completes; req1 is granted next.
  - With both vld asserted again, req0 wins (alternation).
- Counter boundaries:
  - With CNT_W=4, 16 hits → hit_cnt0=15.
  - cnt_clr asserted in the same cycle as a hit → hit_cnt0=0 next cycle.
- Reset mid-packet: rst_n=1 on the 4th SHIFT cycle → next cycle state IDLE, det_vld=0, counters 0, no flush emitted.
